reset_seq: RTL and testbench
============================

RESET_SEQ -- requirements
Module: reset_seq

Interface
REQ-001 Parameter SYNC_STAGES, default 2: synchronizer flop count, legal range 2..4.
REQ-002 Parameter NUM_OUT, default 4: number of sequenced reset outputs, legal range 1..8.
REQ-003 Parameter MIN_ASSERT, default 8: hold cycles after the synchronized release, before the first output release, legal range 1..255.
REQ-004 Parameter STAGE_DLY, default 4: cycles between successive output releases, legal range 1..255.
REQ-005 clk  input  1: single clock; all state is updated on the rising edge.
REQ-006 reset_in  input  1: asynchronous active-low reset.
REQ-007 sw_rst_req  input  1: synchronous software reset request, active high, sampled on clk.
REQ-008 reset_out  output  NUM_OUT: active-low sequenced resets; bit 0 is released first.
REQ-009 done  output  1: high when every reset_out bit is released.
REQ-010 state  output  2: current FSM state encoding (HOLD=0, RELEASE=1, DONE=2).

Function
REQ-011 Synchronizer: a chain of SYNC_STAGES flops with D of stage 0 tied to 1. All stages clear asynchronously on reset_in low. rst_sync is the last stage.
REQ-012 FSM states: HOLD, RELEASE, DONE. One 8-bit delay counter (cnt) and one stage index (idx, width clog2(NUM_OUT+1)).
REQ-013 HOLD: cnt increments each cycle while rst_sync=1 and holds 0 while rst_sync=0. When cnt==MIN_ASSERT-1, release reset_out[0], clear cnt, set idx=1, and go to RELEASE (or DONE if NUM_OUT==1).
REQ-014 RELEASE: cnt increments each cycle. When cnt==STAGE_DLY-1, release reset_out[idx], clear cnt, and increment idx. The edge that releases bit NUM_OUT-1 moves the FSM to DONE.
REQ-015 Release timing: reset_out[0] goes high SYNC_STAGES+MIN_ASSERT rising edges after the first edge that samples reset_in high. reset_out[k] goes high exactly STAGE_DLY edges after reset_out[k-1].
REQ-016 Bits already released stay high until the next reset. Release order is strictly ascending, one bit per release event.
REQ-017 done is registered. It goes high on the same edge as reset_out[NUM_OUT-1], stays high in DONE, and is low in every other state.
REQ-018 reset_out is ANDed combinationally with reset_in, so assertion (low) is immediate and asynchronous. Release is always synchronous to clk.
REQ-019 sw_rst_req=1 in RELEASE or DONE: on the next edge all reset_out bits go low, done goes low, cnt and idx clear, and the FSM enters HOLD. Release then follows REQ-013 with rst_sync already 1, i.e. MIN_ASSERT cycles later.
REQ-020 sw_rst_req=1 in HOLD: cnt clears to 0, which restarts the hold period.
REQ-021 sw_rst_req held high continuously keeps the FSM in HOLD with all outputs low.

Reset
REQ-022 reset_in low, at any time and in any state, asynchronously sets the following, independent of clk:
- synchronizer flops = 0
- state = HOLD
- cnt = 0, idx = 0
- reset_out = all 0
- done = 0
REQ-023 reset_in low in the middle of a release sequence discards all progress. The full sequence of REQ-015 restarts from the next rising edge that samples reset_in high.
REQ-024 A reset_in low pulse shorter than one clk period still asserts every output and restarts the full sequence.

Configuration
REQ-025 Macro RESET_SEQ_SWRST_EN.
- Defined: sw_rst_req behaves per REQ-019..REQ-021.
- Undefined: the sw_rst_req port exists but is ignored (no logic), and the only way to re-enter HOLD is reset_in.

Verification (SYNC_STAGES=2, NUM_OUT=3, MIN_ASSERT=4, STAGE_DLY=3, RESET_SEQ_SWRST_EN defined unless stated; edge 1 = first edge sampling reset_in high)
REQ-026 Power-on: reset_in released before edge 1 -> reset_out goes 3'b000 -> 3'b001 at edge 6, 3'b011 at edge 9, 3'b111 at edge 12; done=1 at edge 12; state=2.
REQ-027 Mid-sequence reset: reset_in pulled low between edges 8 and 9 -> reset_out=3'b000 and done=0 immediately, before the next edge; after re-release, timing is identical to REQ-026.
REQ-028 Glitch: reset_in low for 0.3 clk periods while in DONE -> all outputs low at once, state=HOLD; full sequence repeats.
REQ-029 Software reset: one-cycle sw_rst_req in DONE at edge 20 -> reset_out=3'b000 at edge 21; 3'b001 at edge 25; 3'b111 at edge 31.
REQ-030 HOLD restart: sw_rst_req pulsed at edge 4 during power-on -> reset_out[0] release moves from edge 6 to edge 8.
REQ-031 RESET_SEQ_SWRST_EN undefined: sw_rst_req held high from edge 1 -> outputs follow REQ-026 exactly.

Source files
------------

// File: rtl/reset_seq.sv
// Reset sequencer: synchronizes reset_in release, then releases NUM_OUT resets one by one.
// Optional software reset request is compiled in with `define RESET_SEQ_SWRST_EN.
module reset_seq #(
    parameter int SYNC_STAGES = 2,
    parameter int NUM_OUT     = 4,
    parameter int MIN_ASSERT  = 8,
    parameter int STAGE_DLY   = 4
) (
    input  logic               clk,
    input  logic               reset_in,
    input  logic               sw_rst_req,
    output logic [NUM_OUT-1:0] reset_out,
    output logic               done,
    output logic [1:0]         state
);
    localparam int IDX_W = $clog2(NUM_OUT + 1);
    localparam logic [7:0]       HOLD_LAST = 8'(MIN_ASSERT - 1);
    localparam logic [7:0]       STEP_LAST = 8'(STAGE_DLY - 1);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_OUT - 1);

    typedef enum logic [1:0] {HOLD = 2'd0, RELEASE = 2'd1, DONE = 2'd2} state_e;

    state_e             state_q, state_d;
    logic [7:0]         cnt_q, cnt_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [NUM_OUT-1:0] rout_q, rout_d;
    logic               done_q, done_d;
    logic [SYNC_STAGES-1:0] sync_q;
    logic               rst_sync;
    logic               sw_rst;

    always_ff @(posedge clk or negedge reset_in) begin
        if (!reset_in) sync_q <= '0;
        else           sync_q <= {sync_q[SYNC_STAGES-2:0], 1'b1};
    end
    assign rst_sync = sync_q[SYNC_STAGES-1];

`ifdef RESET_SEQ_SWRST_EN
    assign sw_rst = sw_rst_req;
`else
    logic unused_sw;
    assign unused_sw = sw_rst_req;
    assign sw_rst    = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        rout_d  = rout_q;
        done_d  = done_q;
        unique case (state_q)
            HOLD: begin
                // A software request here only restarts the hold period
                if (sw_rst || !rst_sync) begin
                    cnt_d = '0;
                end else if (cnt_q == HOLD_LAST) begin
                    rout_d[0] = 1'b1;
                    cnt_d     = '0;
                    idx_d     = IDX_W'(1);
                    if (NUM_OUT == 1) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = RELEASE;
                    end
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            RELEASE: begin
                if (sw_rst) begin
                    state_d = HOLD;
                    cnt_d   = '0;
                    idx_d   = '0;
                    rout_d  = '0;
                    done_d  = 1'b0;
                end else if (cnt_q == STEP_LAST) begin
                    for (int k = 0; k < NUM_OUT; k++)
                        if (IDX_W'(k) == idx_q) rout_d[k] = 1'b1;
                    cnt_d = '0;
                    idx_d = idx_q + IDX_W'(1);
                    if (idx_q == IDX_LAST) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            DONE: begin
                if (sw_rst) begin
                    state_d = HOLD;
                    cnt_d   = '0;
                    idx_d   = '0;
                    rout_d  = '0;
                    done_d  = 1'b0;
                end
            end
            default: begin
                state_d = HOLD;
                cnt_d   = '0;
                idx_d   = '0;
                rout_d  = '0;
                done_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_in) begin
        if (!reset_in) begin
            state_q <= HOLD;
            cnt_q   <= '0;
            idx_q   <= '0;
            rout_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            rout_q  <= rout_d;
            done_q  <= done_d;
        end
    end

    // Gating with reset_in makes assertion immediate even between clock edges
    assign reset_out = rout_q & {NUM_OUT{reset_in}};
    assign done      = done_q;
    assign state     = state_q;
endmodule

// File: tb/tb_reset_seq.sv
// Directed bench for reset_seq (SYNC_STAGES=2, NUM_OUT=3, MIN_ASSERT=4, STAGE_DLY=3).
// Software-reset checks run when RESET_SEQ_SWRST_EN is defined, the ignored-port check otherwise.
module tb_reset_seq;
    logic       clk = 1'b0;
    logic       reset_in = 1'b0;
    logic       sw_rst_req = 1'b0;
    logic [2:0] reset_out;
    logic       done;
    logic [1:0] state;
    int         errors = 0;
    int         checks = 0;

    reset_seq #(.SYNC_STAGES(2), .NUM_OUT(3), .MIN_ASSERT(4), .STAGE_DLY(3)) dut (
        .clk(clk), .reset_in(reset_in), .sw_rst_req(sw_rst_req),
        .reset_out(reset_out), .done(done), .state(state)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Walks edges 1..last after a release of reset_in, checking the power-on profile
    task automatic run_seq(input string tag, input int last);
        logic [2:0] exp;
        for (int e = 1; e <= last; e++) begin
            @(posedge clk); #1;
            exp = (e >= 12) ? 3'b111 : (e >= 9) ? 3'b011 : (e >= 6) ? 3'b001 : 3'b000;
            chk($sformatf("%s rout e%0d", tag, e), 8'(reset_out), 8'(exp));
            if (e == 7)  chk($sformatf("%s state e7", tag), 8'(state), 8'd1);
            if (e == 11) chk($sformatf("%s done e11", tag), 8'(done), 8'd0);
            if (e == 12) begin
                chk($sformatf("%s done e12", tag), 8'(done), 8'd1);
                chk($sformatf("%s state e12", tag), 8'(state), 8'd2);
            end
        end
    endtask

    initial begin
        logic [2:0] exp;
        // reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst rout", 8'(reset_out), 8'd0);
        chk("rst done", 8'(done), 8'd0);
        chk("rst state", 8'(state), 8'd0);

`ifdef RESET_SEQ_SWRST_EN
        // power-on
        @(negedge clk); reset_in = 1'b1;
        run_seq("pwr", 12);
`else
        // sw_rst_req held high has no effect
        sw_rst_req = 1'b1;
        @(negedge clk); reset_in = 1'b1;
        run_seq("swoff", 12);
        repeat (5) @(posedge clk);
        #1;
        chk("swoff hold state", 8'(state), 8'd2);
        sw_rst_req = 1'b0;
`endif

        // mid-sequence reset between edges 8 and 9
        reset_in = 1'b0;
        repeat (2) @(negedge clk);
        reset_in = 1'b1;
        run_seq("mid pre", 8);
        #2 reset_in = 1'b0;
        #1;
        chk("mid rout", 8'(reset_out), 8'd0);
        chk("mid done", 8'(done), 8'd0);
        chk("mid state", 8'(state), 8'd0);
        repeat (2) @(negedge clk);
        reset_in = 1'b1;
        run_seq("mid", 12);

        // short glitch while in DONE
        @(negedge clk); #1 reset_in = 1'b0;
        #3;
        chk("glitch rout", 8'(reset_out), 8'd0);
        chk("glitch done", 8'(done), 8'd0);
        chk("glitch state", 8'(state), 8'd0);
        reset_in = 1'b1;
        run_seq("glitch", 12);

`ifdef RESET_SEQ_SWRST_EN
        // one-cycle software request sampled at edge 21
        repeat (8) @(posedge clk);
        #1 sw_rst_req = 1'b1;
        @(posedge clk); #1;
        sw_rst_req = 1'b0;
        chk("sw rout e21", 8'(reset_out), 8'd0);
        chk("sw done e21", 8'(done), 8'd0);
        chk("sw state e21", 8'(state), 8'd0);
        for (int e = 22; e <= 31; e++) begin
            @(posedge clk); #1;
            exp = (e >= 31) ? 3'b111 : (e >= 28) ? 3'b011 : (e >= 25) ? 3'b001 : 3'b000;
            chk($sformatf("sw rout e%0d", e), 8'(reset_out), 8'(exp));
        end
        chk("sw done e31", 8'(done), 8'd1);

        // request held high keeps everything in HOLD
        sw_rst_req = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        chk("swhold rout", 8'(reset_out), 8'd0);
        chk("swhold state", 8'(state), 8'd0);
        sw_rst_req = 1'b0;

        // request at edge 4 of power-on restarts the hold period
        reset_in = 1'b0;
        repeat (2) @(negedge clk);
        reset_in = 1'b1;
        for (int e = 1; e <= 8; e++) begin
            @(posedge clk); #1;
            if (e == 3) sw_rst_req = 1'b1;
            if (e == 4) sw_rst_req = 1'b0;
            chk($sformatf("hrst rout e%0d", e), 8'(reset_out), (e == 8) ? 8'd1 : 8'd0);
        end
        chk("hrst state e8", 8'(state), 8'd1);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
